llr_frame_loader: RTL

- Upstream and downstream companion of the 6-VN/3-CN min-sum decoder.
- Accepts channel LLRs as a serial valid/ready stream and saturates them symmetrically.
- Packs each run of N LLRs into the decoder's flat N*WIDTH LLR vector, pulses the decoder reset, waits for the decoder's done code (or a local timeout), then presents codeword, status and iteration count on a valid/ready output.
- A shadow buffer lets the next frame load while the current frame decodes.

---
 rtl/llr_frame_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/llr_frame_loader.sv
// llr_frame_loader
// Front/back end for the min-sum LDPC decoder. Channel LLRs arrive one per
// beat on a valid/ready stream. Each beat is symmetrically saturated and
// written into a shadow buffer. When N beats have been collected, the frame
// is copied to the decoder-facing register and the decoder is held in reset
// for RST_CYCLES cycles. The loader then waits for the decoder's done code,
// or forces the frame done after TIMEOUT run cycles. The result is presented
// on a valid/ready output. While one frame decodes, the next can already fill
// the shadow buffer.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   cfg_max_iter  iteration limit, latched at frame launch
//   in_valid/in_ready/in_llr            serial LLR input stream
//   dec_llrs      packed frame to the decoder (slot k at [(k+1)*WIDTH-1:k*WIDTH])
//   dec_rst       decoder reset (low only while the frame is running)
//   dec_max_iter  latched iteration limit
//   dec_done/dec_result/dec_iter        decoder status inputs
//   out_valid/out_ready                 result handshake
//   out_cw/out_status/out_iter          captured codeword, status, iterations
//                 (status 10 parity ok, 01 iteration limit, 11 timeout)
module llr_frame_loader #(
   parameter int WIDTH      = 20,
   parameter int N          = 6,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        cfg_max_iter,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_llr,
   output logic [N*WIDTH-1:0]      dec_llrs,
   output logic                    dec_rst,
   output logic [WIDTH-1:0]        dec_max_iter,
   input  logic [1:0]              dec_done,
   input  logic [N-1:0]            dec_result,
   input  logic [WIDTH-1:0]        dec_iter,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N-1:0]            out_cw,
   output logic [1:0]              out_status,
   output logic [WIDTH-1:0]        out_iter
);

   localparam int RUN_W    = $clog2(TIMEOUT) + 1;
   localparam int LAUNCH_W = $clog2(RST_CYCLES) + 1;
   localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_OUTPUT} state_t;

   // The most negative code has no positive counterpart; fold it in by one
   // so the LLR range is symmetric around zero.
   function automatic logic signed [WIDTH-1:0] sat_llr(input logic signed [WIDTH-1:0] x);
      logic signed [WIDTH-1:0] neg_min;
      neg_min = {1'b1, {(WIDTH-1){1'b0}}};
      if (x == neg_min) return {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
      return x;
   endfunction

   state_t                      r_state, w_nstate;
   logic [N-1:0][WIDTH-1:0]     r_shadow;
   logic [IDX_W-1:0]            r_idx;
   logic                        r_shadow_full;
   logic [N*WIDTH-1:0]          r_dec_llrs;
   logic [WIDTH-1:0]            r_max_iter;
   logic [LAUNCH_W-1:0]         r_launch_cnt;
   logic [RUN_W-1:0]            r_run_cnt;
   logic                        r_out_valid;
   logic [N-1:0]                r_out_cw;
   logic [1:0]                  r_out_status;
   logic [WIDTH-1:0]            r_out_iter;

   logic                        w_accept;
   logic                        w_transfer;
   logic                        w_capture;
   logic                        w_handshake;
   logic [1:0]                  w_cap_status;
   logic                        w_dec_rst;

   assign w_accept     = in_valid && !r_shadow_full;
   assign in_ready     = !r_shadow_full;
   assign dec_llrs     = r_dec_llrs;
   assign dec_rst      = w_dec_rst;
   assign dec_max_iter = r_max_iter;
   assign out_valid    = r_out_valid;
   assign out_cw       = r_out_cw;
   assign out_status   = r_out_status;
   assign out_iter     = r_out_iter;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nstate;
   end

   always_comb begin
      w_nstate     = r_state;
      w_transfer   = 1'b0;
      w_capture    = 1'b0;
      w_handshake  = 1'b0;
      w_cap_status = dec_done;
      w_dec_rst    = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (r_shadow_full) begin
               w_transfer = 1'b1;
               w_nstate   = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            if (r_launch_cnt == LAUNCH_W'(RST_CYCLES - 1)) w_nstate = S_RUN;
         end
         S_RUN: begin
            w_dec_rst = 1'b0;
            // A real done code takes priority over the local timeout.
            if (dec_done != 2'b00) begin
               w_capture = 1'b1;
               w_nstate  = S_OUTPUT;
            end else if (r_run_cnt == RUN_W'(TIMEOUT - 1)) begin
               w_capture    = 1'b1;
               w_cap_status = 2'b11;
               w_nstate     = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               w_handshake = 1'b1;
               // Go straight to the next launch when a frame is already waiting.
               if (r_shadow_full) begin
                  w_transfer = 1'b1;
                  w_nstate   = S_LAUNCH;
               end else begin
                  w_nstate = S_IDLE;
               end
            end
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   // Input side: shadow buffer fill, independent of the decode state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx         <= '0;
         r_shadow_full <= 1'b0;
         r_shadow      <= '0;
      end else begin
         if (w_accept) begin
            r_shadow[r_idx] <= sat_llr(in_llr);
            if (r_idx == IDX_W'(N - 1)) begin
               r_idx         <= '0;
               r_shadow_full <= 1'b1;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end else if (w_transfer) begin
            r_shadow_full <= 1'b0;
         end
      end
   end

   // Decode side: frame launch, counters and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dec_llrs   <= '0;
         r_max_iter   <= '0;
         r_launch_cnt <= '0;
         r_run_cnt    <= '0;
         r_out_valid  <= 1'b0;
         r_out_cw     <= '0;
         r_out_status <= 2'b00;
         r_out_iter   <= '0;
      end else begin
         if (w_transfer) begin
            r_dec_llrs <= r_shadow;
            r_max_iter <= cfg_max_iter;
         end
         r_launch_cnt <= (r_state == S_LAUNCH) ? r_launch_cnt + 1'b1 : '0;
         r_run_cnt    <= (r_state == S_RUN)    ? r_run_cnt + 1'b1    : '0;
         if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_out_cw     <= dec_result;
            r_out_status <= w_cap_status;
            r_out_iter   <= dec_iter;
         end else if (w_handshake) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule
